// File: rtl/mod_boot_loader.sv
// Serial program loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from the UART,
// writes assembled 32-bit words to RAM and answers each frame with ACK or NAK.
//
// state  | meaning
// IDLE   | waiting for SYNC_BYTE, all other bytes dropped
// ADDR   | collecting 4 big-endian base address bytes
// LEN    | collecting 2 big-endian word-count bytes
// DATA   | collecting data bytes, one RAM write per completed word
// CSUM   | waiting for the XOR checksum byte
// RESP   | holding ACK/NAK on tx until tx_ready
module mod_boot_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 2048,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        de,
  output logic        drw,
  output logic [31:0] daddr,
  output logic [31:0] din,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    hdr_cnt_q, hdr_cnt_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          de_q, de_d;
  logic [31:0]   daddr_q, daddr_d;
  logic [31:0]   din_q, din_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [15:0]   len_new;

  assign len_new = {len_q[7:0], rx_data};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    tmr_d      = tmr_q;
    de_d       = 1'b0;
    daddr_d    = 32'd0;
    din_d      = 32'd0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d    = S_ADDR;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          hdr_cnt_d  = 2'd0;
          byte_cnt_d = 2'd0;
          word_idx_d = 16'd0;
          csum_d     = 8'd0;
          tmr_d      = TMR_LOAD;
        end
      end

      S_ADDR, S_LEN, S_DATA, S_CSUM: begin
        if (rx_valid) begin
          tmr_d = TMR_LOAD;
          if (state_q == S_ADDR) begin
            addr_d    = {addr_q[23:0], rx_data};
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd3) begin
              addr_d    = {addr_q[23:0], rx_data[7:2], 2'b00};
              hdr_cnt_d = 2'd0;
              state_d   = S_LEN;
            end
          end else if (state_q == S_LEN) begin
            len_d = len_new;
            if (hdr_cnt_q == 2'd0) begin
              hdr_cnt_d = 2'd1;
            end else begin
              hdr_cnt_d  = 2'd0;
              word_idx_d = 16'd0;
              byte_cnt_d = 2'd0;
              if (len_new == 16'd0) begin
                state_d = S_CSUM;
              end else if (32'(len_new) > 32'(MAX_WORDS)) begin
                state_d    = S_RESP;
                tx_valid_d = 1'b1;
                tx_data_d  = NAK;
                err_d      = 1'b1;
              end else begin
                state_d = S_DATA;
              end
            end
          end else if (state_q == S_DATA) begin
            word_d     = {word_q[23:0], rx_data};
            csum_d     = csum_q ^ rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              de_d       = 1'b1;
              daddr_d    = addr_q + {14'd0, word_idx_q, 2'b00};
              din_d      = {word_q[23:0], rx_data};
              word_idx_d = word_idx_q + 16'd1;
              if (word_idx_q == len_q - 16'd1) state_d = S_CSUM;
            end
          end else begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            if (rx_data == csum_q) begin
              tx_data_d = ACK;
            end else begin
              tx_data_d = NAK;
              err_d     = 1'b1;
            end
          end
        end else if (tmr_q == '0) begin
          // silent abort: no response byte, partial word dropped
          state_d    = S_IDLE;
          err_d      = 1'b1;
          busy_d     = 1'b0;
          hdr_cnt_d  = 2'd0;
          byte_cnt_d = 2'd0;
          word_idx_d = 16'd0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      S_RESP: begin
        if (tx_ready) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      len_q      <= 16'd0;
      word_idx_q <= 16'd0;
      hdr_cnt_q  <= 2'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      csum_q     <= 8'd0;
      tmr_q      <= '0;
      de_q       <= 1'b0;
      daddr_q    <= 32'd0;
      din_q      <= 32'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      tmr_q      <= tmr_d;
      de_q       <= de_d;
      daddr_q    <= daddr_d;
      din_q      <= din_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign de       = de_q;
  assign drw      = de_q;
  assign daddr    = daddr_q;
  assign din      = din_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mod_boot_loader.sv
// Randomized frame stimulus; expected RAM writes and ACK/NAK bytes are queued by
// a frame-level model and matched by an independent output monitor.
module tb_mod_boot_loader;

  localparam int TO   = 50;
  localparam int MAXW = 2048;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        de, drw;
  logic [31:0] daddr, din;
  logic        busy, err;

  mod_boot_loader #(.SYNC_BYTE(8'hA5), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .de(de), .drw(drw), .daddr(daddr), .din(din), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  logic [7:0]  rq[$];
  logic [31:0] wbuf[$];
  int          cyc = 0;
  int          last_cyc;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // output monitor
  bit         prev_v = 0, prev_acc = 0;
  logic [7:0] prev_d = 8'd0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0;
    end else begin
      if (de) begin
        chk("drw_eq_de", {63'd0, drw}, {63'd0, de});
        if (wq.size() == 0) chk("unexpected_write", {32'd0, daddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("daddr", {32'd0, daddr}, {32'd0, e.addr});
          chk("din", {32'd0, din}, {32'd0, e.data});
          chk("de_latency", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("idle_bus_zero", {63'd0, (|daddr) | (|din) | drw}, 64'd0);
      end
      if (prev_v && !prev_acc) begin
        chk("tx_valid_hold", {63'd0, tx_valid}, 64'd1);
        if (tx_valid) chk("tx_data_stable", {56'd0, tx_data}, {56'd0, prev_d});
      end
      if (tx_valid && tx_ready) begin
        if (rq.size() == 0) chk("unexpected_resp", {56'd0, tx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("tx_data", {56'd0, tx_data}, {56'd0, rq.pop_front()});
      end
      prev_v   = tx_valid;
      prev_d   = tx_data;
      prev_acc = tx_valid && tx_ready;
    end
  end

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    last_cyc = cyc;
  endtask

  task automatic wait_resp(input int low_cycles);
    int seen = 0;
    bit acc;
    bit done = 0;
    tx_ready = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      acc = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (acc) begin
        done = 1;
        tx_ready = 1'b0;
      end else if (tx_valid) begin
        seen++;
        tx_ready = (seen > low_cycles) && ($urandom_range(0, 3) != 0);
      end
    end
    chk("resp_accepted", {63'd0, done}, 64'd1);
  endtask

  // Frame-level reference: writes go to (addr with low bits cleared) + 4*i,
  // checksum is the XOR of all data bytes, LEN beyond MAX_WORDS is NAKed after LEN.
  task automatic run_frame(input logic [31:0] addr, input int len, input int csum_ovr,
                           input int gap_max, input int long_gap, input int low_cycles);
    logic [7:0]  cs = 8'd0;
    logic [7:0]  sent_cs, b;
    logic [31:0] w, base;
    logic [15:0] l16;
    bit          exp_err;
    l16  = 16'(len);
    base = addr & 32'hFFFF_FFFC;
    send_byte(8'hA5);
    chk("busy_after_sync", {63'd0, busy}, 64'd1);
    chk("err_cleared_by_sync", {63'd0, err}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      gap($urandom_range(0, gap_max));
      send_byte(addr[31-8*i -: 8]);
    end
    gap($urandom_range(0, gap_max));
    send_byte(l16[15:8]);
    gap($urandom_range(0, gap_max));
    send_byte(l16[7:0]);
    if (len > MAXW) begin
      rq.push_back(NAK);
      exp_err = 1;
    end else begin
      for (int wi = 0; wi < len; wi++) begin
        w = (wi < wbuf.size()) ? wbuf[wi] : $urandom;
        for (int k = 0; k < 4; k++) begin
          b  = w[31-8*k -: 8];
          cs = cs ^ b;
          gap($urandom_range(0, gap_max));
          send_byte(b);
        end
        wq.push_back('{base + 32'(4 * wi), w, last_cyc});
      end
      gap(long_gap);
      sent_cs = (csum_ovr < 0) ? cs : 8'(csum_ovr);
      exp_err = (sent_cs != cs);
      rq.push_back(exp_err ? NAK : ACK);
      gap($urandom_range(0, gap_max));
      send_byte(sent_cs);
    end
    wait_resp(low_cycles);
    chk("busy_after_resp", {63'd0, busy}, 64'd0);
    chk("err_after_frame", {63'd0, err}, {63'd0, exp_err});
  endtask

  task automatic partial_frame(input logic [31:0] addr, input int ndata);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(addr[31-8*i -: 8]);
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < ndata; i++) send_byte(8'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] j;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b0;
    gap(3);
    chk("rst_de", {63'd0, de}, 64'd0);
    chk("rst_daddr", {32'd0, daddr}, 64'd0);
    chk("rst_din", {32'd0, din}, 64'd0);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_tx_data", {56'd0, tx_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    gap(2);

    // directed frame, correct checksum
    wbuf = '{32'h11223344, 32'h55667788};
    run_frame(32'h0000_0010, 2, -1, 1, 0, 0);
    // same frame, checksum 00 forces NAK but keeps the writes
    run_frame(32'h0000_0010, 2, 0, 1, 0, 0);
    wbuf.delete();
    // junk before SYNC, LEN=0
    send_byte(8'h00); send_byte(8'hFF);
    chk("junk_ignored_busy", {63'd0, busy}, 64'd0);
    run_frame(32'h0000_0000, 0, -1, 0, 0, 0);
    // LEN = MAX_WORDS+1
    run_frame(32'h0000_0000, MAXW + 1, -1, 0, 0, 0);

    // reset mid-DATA clears everything including sticky err
    partial_frame(32'h0000_0100, 2);
    rst = 1'b1;
    gap(2);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_err", {63'd0, err}, 64'd0);
    chk("midrst_de", {63'd0, de}, 64'd0);
    rst = 1'b0;
    gap(1);
    // reset coincident with the last byte of a word: write suppressed
    partial_frame(32'h0000_0200, 3);
    rx_data = 8'h5A; rx_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_suppress_de", {63'd0, de}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wbuf = '{32'h11223344, 32'h55667788};
    run_frame(32'h0000_0010, 2, -1, 0, 0, 5);
    wbuf.delete();

    // timeout after 2 data bytes
    partial_frame(32'h0000_0300, 2);
    gap(TO - 3);
    chk("pre_timeout_busy", {63'd0, busy}, 64'd1);
    gap(10);
    chk("timeout_busy", {63'd0, busy}, 64'd0);
    chk("timeout_err", {63'd0, err}, 64'd1);
    chk("timeout_no_tx", {63'd0, tx_valid}, 64'd0);
    // long but legal gap, and an address that wraps past 2^32
    run_frame(32'hFFFF_FFF7, 4, -1, 1, TO - 5, 2);

    // randomized frames with junk in between
    for (int f = 0; f < 15; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        send_byte(j);
      end
      run_frame($urandom, $urandom_range(0, 6),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1,
                2, 0, $urandom_range(0, 3));
    end

    // maximum legal frame, back-to-back bytes
    run_frame($urandom, MAXW, -1, 0, 0, 0);

    gap(5);
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("resps_drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
